uart_rx_buffer: RTL and testbench

Serial-line receiver buffer feeding the flash programmer's command decoder. Recovers 8N1 asynchronous frames from the RS-232 receive pin, checks start and stop bits, and presents each byte through a single holding register with a ready/read handshake. The returned byte stays stable after it is read, because the command decoder samples `data_out` for one more cycle after asserting `read`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx_buffer.sv | 136 +++++++++++++
 tb/tb_uart_rx_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the 8N1 UART receive buffer.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int DATA_BITS        = 8;
    localparam int SYNC_STAGES      = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line does not fake a start.
module sync_2ff
    import uart_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff_q;
    logic [SYNC_STAGES-1:0] ff_d;

    always_comb ff_d = {ff_q[SYNC_STAGES-2:0], d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= {SYNC_STAGES{RST_VAL}};
        else     ff_q <= ff_d;
    end

    assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 receiver with start/stop checking and a single holding register whose
// contents survive a read, so the consumer may sample data_out after popping.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       read,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (reset),
        .d   (serial_in),
        .q   (rx_s)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             stop_ok;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        stop_ok     = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (clk_cnt_q == CNT_MID) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        stop_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off start detection until the line break ends.
                clk_cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d   = ready_q;
        data_d    = data_q;
        overrun_d = 1'b0;

        if (read && ready_q) ready_d = 1'b0;

        // A read in the delivery clock frees the slot for the new byte.
        if (stop_ok) begin
            if (!ready_q || read) begin
                data_d  = shift_q;
                ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ready     = ready_q;
    assign data_out  = data_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench: stimulus pushes expected events (byte, overrun, framing
// error) with their due cycle; a negedge monitor pops them as the DUT reports.
module tb_uart_rx_buffer;

    localparam int C      = 16;
    localparam int K_DLV  = 0;
    localparam int K_OVR  = 1;
    localparam int K_FERR = 2;
    // Driven start edge to ready: 2 sync clocks, 1 detect clock, 9.5 bits.
    localparam int LAT    = 3 + C / 2 + 9 * C - 1 + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       rd_man = 1'b0;
    logic       rd_auto = 1'b0;
    logic       read;
    logic       ready;
    logic [7:0] data_out;
    logic       overrun;
    logic       frame_err;

    assign read = rd_man | rd_auto;

    uart_rx_buffer #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .read      (read),
        .ready     (ready),
        .data_out  (data_out),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t  exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   auto_rd = 1'b0;
    bit   model_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected none (cycle %0d)",
                     kind, data_out, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.at);
            if (e.kind == K_DLV) check("data_out", {24'd0, data_out}, {24'd0, e.data});
        end
    endtask

    // Monitor: a delivery is a ready rise or a data change while ready stays high.
    logic       rdy_prev = 1'b0;
    logic [7:0] dat_prev = 8'h00;
    always @(negedge clk) begin
        if (!reset) begin
            if (overrun)   mon_event(K_OVR);
            if (frame_err) mon_event(K_FERR);
            if ((ready && !rdy_prev) || (data_out != dat_prev)) mon_event(K_DLV);
        end
        rdy_prev <= ready;
        dat_prev <= data_out;
    end

    // Consumer that pops one clock after ready rises.
    always @(negedge clk) begin
        if (rd_auto)                          rd_auto <= 1'b0;
        else if (auto_rd && ready && !reset)  rd_auto <= 1'b1;
    end

    // Called at a negedge; drives one frame, optionally truncated after max_clks.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int kind, input int max_clks);
        ev_t e;
        int  n;
        bit  v;
        if (kind >= 0) begin
            e.kind = kind;
            e.data = d;
            e.at   = cyc + LAT;
            exp_q.push_back(e);
        end
        n = 0;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = stop;
            else             v = d[b-1];
            for (int k = 0; k < C; k++) begin
                if (n == max_clks) return;
                serial_in = v;
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pop_read(input string name, input logic [7:0] exp);
        rd_man = 1'b1;
        @(negedge clk);
        rd_man = 1'b0;
        check({name, "_ready_after_read"}, {31'd0, ready}, 32'd0);
        check({name, "_data_after_read"}, {24'd0, data_out}, {24'd0, exp});
        model_full = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"},     {31'd0, ready},     32'd0);
        check({name, "_data_out"},  {24'd0, data_out},  32'd0);
        check({name, "_overrun"},   {31'd0, overrun},   32'd0);
        check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         bad;
        int         kind;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(5);

        // Single byte, consumer idle, then a pop that keeps data_out.
        send_frame(8'hA5, 1'b1, K_DLV, -1);
        model_full = 1'b1;
        drain("a5");
        idle(3);
        pop_read("a5", 8'hA5);
        idle(5);

        // Back-to-back frames with prompt pops.
        auto_rd = 1'b1;
        send_frame(8'h8A, 1'b1, K_DLV, -1);
        send_frame(8'h3C, 1'b1, K_DLV, -1);
        drain("b2b");
        idle(5);
        auto_rd = 1'b0;

        // Second byte while full is dropped.
        send_frame(8'h11, 1'b1, K_DLV, -1);
        model_full = 1'b1;
        send_frame(8'h22, 1'b1, K_OVR, -1);
        drain("ovr");
        check("ovr_data_kept", {24'd0, data_out}, 32'h11);
        check("ovr_ready_kept", {31'd0, ready}, 32'd1);

        // Read in the stop-sample clock lets the new byte replace 0x11.
        fork
            send_frame(8'h55, 1'b1, K_DLV, -1);
            begin
                repeat (LAT - 1) @(negedge clk);
                rd_man = 1'b1;
                @(negedge clk);
                rd_man = 1'b0;
            end
        join
        drain("rd_deliver");
        check("rd_deliver_ready", {31'd0, ready}, 32'd1);
        check("rd_deliver_data", {24'd0, data_out}, 32'h55);
        pop_read("x55", 8'h55);
        idle(5);

        // Glitch, bad stop bit with line break, then a good frame.
        serial_in = 1'b0;
        repeat (5) @(negedge clk);
        idle(30);
        send_frame(8'h96, 1'b0, K_FERR, -1);
        serial_in = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        drain("ferr");
        check("ferr_ready", {31'd0, ready}, 32'd0);
        auto_rd = 1'b1;
        send_frame(8'h7E, 1'b1, K_DLV, -1);
        drain("after_break");
        idle(5);
        auto_rd = 1'b0;

        // Reset during data bit 4, then a clean frame.
        send_frame(8'h99, 1'b1, -1, 5 * C + C / 2);
        serial_in = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe_reset");
        reset = 1'b0;
        idle(5);
        auto_rd = 1'b1;
        send_frame(8'hC3, 1'b1, K_DLV, -1);
        drain("post_reset");
        idle(5);

        // Randomized frames against the occupancy model.
        model_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d       = 8'($urandom);
            bad     = ($urandom_range(0, 4) == 0);
            auto_rd = 1'($urandom_range(0, 1));
            if (auto_rd) model_full = 1'b0;
            if (bad)             kind = K_FERR;
            else if (model_full) kind = K_OVR;
            else                 kind = K_DLV;
            if (!bad && !model_full && !auto_rd) model_full = 1'b1;
            send_frame(d, !bad, kind, -1);
            if (bad) idle($urandom_range(2, 10));
            else     idle($urandom_range(0, 10));
        end
        drain("random");
        idle(10);
        auto_rd = 1'b0;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
